// File: rtl/conv2_sched.sv
// ---------------------------------------------------------------------------
// conv2_sched
//   Sequencer for the second convolution layer. It counts the incoming
//   3-channel pixel stream, recognises the pixel that completes a KxK window
//   in the line buffer, and then time-shares a single conv2 calc engine
//   across N_OCH output channels. While it steps through the channels it
//   holds off the input stream.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_start      begin one feature map (honoured only when idle)
//   i_in_valid   upstream pixel triplet valid
//   o_in_ready   pixel can be accepted (filling only)
//   o_buf_we     line-buffer shift enable (i_in_valid & o_in_ready)
//   o_out_valid  window/channel issue valid towards the calc engine
//   i_out_ready  downstream accepts the current issue
//   o_ch_sel     weight-bank / output-channel index of the current issue
//   o_win_row    top-left row of the current window
//   o_win_col    top-left column of the current window
//   o_last       current issue is the final window on the final channel
//   o_busy       high whenever a map is in progress
//   o_done       one-cycle pulse after the final issue has been accepted
// ---------------------------------------------------------------------------
module conv2_sched #(
  parameter int IMG_W = 12,
  parameter int K     = 3,
  parameter int N_OCH = 3,
  parameter int CH_W  = 2,
  parameter int RC_W  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  output logic            o_buf_we,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [CH_W-1:0] o_ch_sel,
  output logic [RC_W-1:0] o_win_row,
  output logic [RC_W-1:0] o_win_col,
  output logic            o_last,
  output logic            o_busy,
  output logic            o_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [RC_W-1:0] LP_KM1     = RC_W'(K - 1);
  localparam logic [RC_W-1:0] LP_POS_MAX = RC_W'(IMG_W - 1);
  localparam logic [RC_W-1:0] LP_WIN_MAX = RC_W'(IMG_W - K);
  localparam logic [CH_W-1:0] LP_CH_MAX  = CH_W'(N_OCH - 1);
  localparam logic [CH_W-1:0] LP_CH_ONE  = CH_W'(1);
  localparam logic [RC_W-1:0] LP_RC_ONE  = RC_W'(1);

  state_t          r_state;
  logic [RC_W-1:0] r_row;
  logic [RC_W-1:0] r_col;
  logic [CH_W-1:0] r_ch_sel;
  logic [RC_W-1:0] r_win_row;
  logic [RC_W-1:0] r_win_col;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_last;
  logic            r_busy;
  logic            r_done;

  state_t          w_state_nxt;
  logic [RC_W-1:0] w_row_nxt;
  logic [RC_W-1:0] w_col_nxt;
  logic [CH_W-1:0] w_ch_sel_nxt;
  logic [RC_W-1:0] w_win_row_nxt;
  logic [RC_W-1:0] w_win_col_nxt;
  logic            w_in_ready_nxt;
  logic            w_out_valid_nxt;
  logic            w_last_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_accept;
  logic            w_fire;
  logic            w_win_hit;

  // Handshake decode; r_in_ready is only ever set while filling.
  assign w_accept  = i_in_valid & r_in_ready;
  assign w_fire    = r_out_valid & i_out_ready;
  // The accepted pixel completes a window only once it is at least K-1 in
  // from the top and left edges; pixels in columns 0..K-2 only shift in.
  assign w_win_hit = (r_row >= LP_KM1) & (r_col >= LP_KM1);

  // Next-state, counter and registered-output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    w_ch_sel_nxt  = r_ch_sel;
    w_win_row_nxt = r_win_row;
    w_win_col_nxt = r_win_col;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_FILL;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_FILL: begin
        if (w_accept) begin
          // Raster position advances with every accepted pixel; the row
          // wraps after the final pixel so it never leaves 0..IMG_W-1.
          if (r_col == LP_POS_MAX) begin
            w_col_nxt = '0;
            if (r_row == LP_POS_MAX) begin
              w_row_nxt = '0;
            end else begin
              w_row_nxt = r_row + LP_RC_ONE;
            end
          end else begin
            w_col_nxt = r_col + LP_RC_ONE;
          end

          if (w_win_hit) begin
            w_state_nxt   = ST_ISSUE;
            w_win_row_nxt = r_row - LP_KM1;
            w_win_col_nxt = r_col - LP_KM1;
            w_ch_sel_nxt  = '0;
          end else begin
            w_state_nxt = ST_FILL;
          end
        end else begin
          w_state_nxt = ST_FILL;
        end
      end

      ST_ISSUE: begin
        if (w_fire) begin
          if (r_ch_sel != LP_CH_MAX) begin
            w_ch_sel_nxt = r_ch_sel + LP_CH_ONE;
          end else if (r_last) begin
            w_state_nxt  = ST_DONE;
            w_ch_sel_nxt = '0;
          end else begin
            w_state_nxt  = ST_FILL;
            w_ch_sel_nxt = '0;
          end
        end else begin
          // Stalled: window and channel stay frozen for the calc engine.
          w_state_nxt = ST_ISSUE;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Status flags are decoded from the next state so they come out of flops.
    w_in_ready_nxt  = (w_state_nxt == ST_FILL);
    w_out_valid_nxt = (w_state_nxt == ST_ISSUE);
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    w_done_nxt      = (w_state_nxt == ST_DONE);
    w_last_nxt      = w_out_valid_nxt
                    & (w_win_row_nxt == LP_WIN_MAX)
                    & (w_win_col_nxt == LP_WIN_MAX)
                    & (w_ch_sel_nxt == LP_CH_MAX);
  end

  // State, counters and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_ch_sel    <= '0;
      r_win_row   <= '0;
      r_win_col   <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_ch_sel    <= w_ch_sel_nxt;
      r_win_row   <= w_win_row_nxt;
      r_win_col   <= w_win_col_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_last      <= w_last_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_buf_we    = w_accept;
  assign o_out_valid = r_out_valid;
  assign o_ch_sel    = r_ch_sel;
  assign o_win_row   = r_win_row;
  assign o_win_col   = r_win_col;
  assign o_last      = r_last;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_conv2_sched.sv
// ---------------------------------------------------------------------------
// tb_conv2_sched
//   Self-checking bench for conv2_sched. A raster model of the pixel stream
//   pushes the expected window/channel issues into a queue on every accepted
//   pixel; issues are popped and compared as the DUT hands them over.
// ---------------------------------------------------------------------------
module tb_conv2_sched;

  localparam int IMG_W = 12;
  localparam int K     = 3;
  localparam int N_OCH = 3;
  localparam int CH_W  = 2;
  localparam int RC_W  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            in_ready;
  logic            buf_we;
  logic            out_valid;
  logic [CH_W-1:0] ch_sel;
  logic [RC_W-1:0] win_row;
  logic [RC_W-1:0] win_col;
  logic            last;
  logic            busy;
  logic            done;

  conv2_sched #(
    .IMG_W(IMG_W), .K(K), .N_OCH(N_OCH), .CH_W(CH_W), .RC_W(RC_W)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .o_buf_we   (buf_we),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_ch_sel   (ch_sel),
    .o_win_row  (win_row),
    .o_win_col  (win_col),
    .o_last     (last),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH_W-1:0] ch;
    logic [RC_W-1:0] wr;
    logic [RC_W-1:0] wc;
    logic            lst;
  } iss_t;

  typedef struct {
    logic       s;
    logic       v;
    logic       r;
    logic [4:0] exp; // {in_ready, out_valid, buf_we, busy, done}
  } vec_t;

  iss_t sb[$];
  int   n_pass = 0;
  int   n_chk  = 0;
  int   n_acc, n_iss, n_done;
  int   m_row, m_col;
  bit   m_hit_due, m_miss_due, m_done_due, m_idle_due;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0;
    n_acc = 0; n_iss = 0; n_done = 0;
    m_hit_due = 1'b0; m_miss_due = 1'b0; m_done_due = 1'b0; m_idle_due = 1'b0;
    sb.delete();
  endtask

  // Called just before the active edge with the inputs already applied.
  task automatic monitor();
    iss_t e;
    if (m_hit_due) begin
      check("hit_to_out_valid_latency", {31'd0, out_valid}, 32'd1);
      m_hit_due = 1'b0;
    end
    if (m_miss_due) begin
      check("rowwrap_no_issue", {30'd0, in_ready, out_valid}, 32'd2);
      m_miss_due = 1'b0;
    end
    if (m_done_due) begin
      check("done_pulse_busy", {30'd0, done, busy}, 32'd3);
      m_done_due = 1'b0;
      m_idle_due = 1'b1;
    end else if (m_idle_due) begin
      check("idle_after_done", {30'd0, done, busy}, 32'd0);
      m_idle_due = 1'b0;
    end
    check("ready_valid_exclusive", {31'd0, in_ready & out_valid}, 32'd0);
    if (done) n_done++;
    if (buf_we) begin
      n_acc++;
      if (m_row >= K - 1 && m_col >= K - 1) begin
        for (int c = 0; c < N_OCH; c++) begin
          e.ch  = CH_W'(c);
          e.wr  = RC_W'(m_row - (K - 1));
          e.wc  = RC_W'(m_col - (K - 1));
          e.lst = (m_row == IMG_W - 1) && (m_col == IMG_W - 1) && (c == N_OCH - 1);
          sb.push_back(e);
        end
        m_hit_due = 1'b1;
      end else begin
        m_miss_due = 1'b1;
      end
      if (m_col == IMG_W - 1) begin
        m_col = 0;
        m_row++;
      end else begin
        m_col++;
      end
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_issue");
      end else begin
        e = sb.pop_front();
        n_iss++;
        check("issue_ch_row_col_last", {21'd0, ch_sel, win_row, win_col, last},
              {21'd0, e.ch, e.wr, e.wc, e.lst});
        if (n_iss == 1) check("accepts_before_first_issue", n_acc, 32'd27);
        if (e.lst) m_done_due = 1'b1;
      end
    end
  endtask

  task automatic step(input logic s, input logic v, input logic r);
    @(negedge clk);
    start = s; in_valid = v; out_ready = r;
    #1;
    monitor();
  endtask

  task automatic start_map();
    model_reset();
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_to_done(input bit rnd, input int budget);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      if (rnd) step(($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 3) != 0));
      else     step(1'b0, 1'b1, 1'b1);
      k++;
    end
    if (n_done == 0) fail_now("timeout_waiting_done");
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_totals(input string tag);
    check({tag, "_accepts"}, n_acc, 32'd144);
    check({tag, "_issues"}, n_iss, 32'd300);
    check({tag, "_done_pulses"}, n_done, 32'd1);
    check({tag, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int k;
    vecs[0] = '{s:1'b0, v:1'b0, r:1'b0, exp:5'b00000};
    vecs[1] = '{s:1'b1, v:1'b0, r:1'b0, exp:5'b00000};
    vecs[2] = '{s:1'b0, v:1'b0, r:1'b0, exp:5'b10010};
    vecs[3] = '{s:1'b1, v:1'b1, r:1'b0, exp:5'b10110};
    vecs[4] = '{s:1'b0, v:1'b0, r:1'b1, exp:5'b10010};
    vecs[5] = '{s:1'b1, v:1'b1, r:1'b1, exp:5'b10110};

    // Reset state
    #2 rst_n = 1'b0;
    #3;
    check("reset_outputs", {20'd0, in_ready, buf_we, out_valid, ch_sel, win_row, win_col,
                            last, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Idle, start and ignored starts while filling
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].s, vecs[i].v, vecs[i].r);
      check($sformatf("vec%0d_flags", i), {27'd0, in_ready, out_valid, buf_we, busy, done},
            {27'd0, vecs[i].exp});
    end

    // Run into the second window, then stall mid-window with a stray start
    k = 0;
    while (n_iss < 4 && k < 300) begin
      step(1'b0, 1'b1, 1'b1);
      k++;
    end
    if (n_iss < 4) fail_now("timeout_waiting_issue4");
    for (int i = 0; i < 5; i++) begin
      step((i == 2), 1'b1, 1'b0);
      check("stall_flags", {29'd0, out_valid, in_ready, buf_we}, 32'd4);
      if (sb.size() == 0) fail_now("stall_sb_empty");
      else check("stall_held_ch_win", {22'd0, ch_sel, win_row, win_col},
                 {22'd0, sb[0].ch, sb[0].wr, sb[0].wc});
    end
    check("stall_held_ch_is_1", {30'd0, ch_sel}, 32'd1);
    run_to_done(1'b0, 3000);
    check_totals("map1");

    // Second map with random handshakes and stray starts
    start_map();
    run_to_done(1'b1, 8000);
    check_totals("map2");

    // Third map, asynchronous reset in the middle of window (4,4) channel 1
    start_map();
    k = 0;
    while (n_iss < 133 && k < 2000) begin
      step(1'b0, 1'b1, 1'b1);
      k++;
    end
    if (n_iss < 133) fail_now("timeout_waiting_win44");
    step(1'b0, 1'b1, 1'b0);
    check("pre_reset_issue", {21'd0, out_valid, ch_sel, win_row, win_col},
          {21'd0, 1'b1, 2'd1, 4'd4, 4'd4});
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {20'd0, in_ready, buf_we, out_valid, ch_sel, win_row, win_col,
                                  last, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_map();
    run_to_done(1'b0, 3000);
    check_totals("map3");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
